// File: rtl/qos_pkg.sv
// rtl/qos_pkg.sv - shared state encodings, arbiter modes and word-field helpers
// Contents: state_e (RESET/INIT/IDLE/ACTIVE), ARB_SP/ARB_RR, dest_of(), vc_of().
package qos_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_e;

    localparam int ARB_SP = 0;
    localparam int ARB_RR = 1;

    // Destination field: top dst_w bits of the word.
    function automatic logic [31:0] dest_of(logic [63:0] word, int data_w, int dst_w);
        return 32'((word >> (data_w - dst_w)) & ((64'd1 << dst_w) - 64'd1));
    endfunction

    // VC field: the vc_w bits directly below the destination field.
    function automatic logic [31:0] vc_of(logic [63:0] word, int data_w, int dst_w, int vc_w);
        return 32'((word >> (data_w - dst_w - vc_w)) & ((64'd1 << vc_w) - 64'd1));
    endfunction

endpackage

// File: rtl/qos_vc_router_if.sv
// rtl/qos_vc_router_if.sv - ingress/egress bus of the QoS VC router
// master: drives Main_wr, Main_data_in, D_rd; observes Main_full, Main_pause, D_data_out, D_empty.
// slave : the router side of the same signals.
interface qos_vc_router_if #(
    parameter int DATA_W   = 6,
    parameter int NUM_DEST = 2
);
    logic                       Main_wr;
    logic [DATA_W-1:0]          Main_data_in;
    logic                       Main_full;
    logic                       Main_pause;
    logic [NUM_DEST-1:0]        D_rd;
    logic [NUM_DEST*DATA_W-1:0] D_data_out;
    logic [NUM_DEST-1:0]        D_empty;

    modport master (
        output Main_wr, Main_data_in, D_rd,
        input  Main_full, Main_pause, D_data_out, D_empty
    );

    modport slave (
        input  Main_wr, Main_data_in, D_rd,
        output Main_full, Main_pause, D_data_out, D_empty
    );
endinterface

// File: rtl/qos_sync_fifo.sv
// rtl/qos_sync_fifo.sv - synchronous show-ahead FIFO with registered count
// Ports: clk, reset_L (async active-low), wr/rd requests, data_in, data_out (head, 0 when empty),
//        count, empty, full, err_of (write while full), err_uf (read while empty).
module qos_sync_fifo #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       err_of,
    output logic                       err_uf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_wr;
    logic              w_do_rd;

    assign empty    = (r_count == '0);
    assign full     = (r_count == CW'(DEPTH));
    assign count    = r_count;
    // Rejected requests leave pointers untouched and only raise the error pulse.
    assign w_do_wr  = wr && !full;
    assign w_do_rd  = rd && !empty;
    assign err_of   = wr && full;
    assign err_uf   = rd && empty;
    assign data_out = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/qos_vc_router.sv
// rtl/qos_vc_router.sv - Main FIFO -> VC FIFOs -> egress FIFOs router with threshold backpressure
// Ports: clk, reset_L (async active-low), init, umbral_alto (almost-full threshold),
//        bus (slave: Main_wr/Main_data_in/Main_full/Main_pause/D_rd/D_data_out/D_empty),
//        VC_empty, error_out {D, VC, Main overflow, Main underflow}, state, idle_out.
module qos_vc_router
    import qos_pkg::*;
#(
    parameter int DATA_W     = 6,
    parameter int NUM_VC     = 4,
    parameter int NUM_DEST   = 2,
    parameter int MAIN_DEPTH = 8,
    parameter int VC_DEPTH   = 16,
    parameter int DEST_DEPTH = 4,
    parameter int ARB_MODE   = ARB_SP,
    localparam int VC_W      = $clog2(NUM_VC),
    localparam int DST_W     = $clog2(NUM_DEST),
    localparam int CNT_W     = $clog2(VC_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic                           init,
    input  logic [CNT_W-1:0]               umbral_alto,
    qos_vc_router_if.slave                 bus,
    output logic [NUM_VC-1:0]              VC_empty,
    output logic [2+NUM_VC+NUM_DEST-1:0]   error_out,
    output logic [1:0]                     state,
    output logic                           idle_out
);
    localparam int MAIN_CW = $clog2(MAIN_DEPTH) + 1;
    localparam int DEST_CW = $clog2(DEST_DEPTH) + 1;
    localparam int ERR_W   = 2 + NUM_VC + NUM_DEST;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_thr;
    logic [VC_W-1:0]   r_rr_last;
    logic [ERR_W-1:0]  r_err;

    logic w_live;
    logic w_run;
    logic w_any_data;
    int   w_thr_main;
    int   w_thr_vc;
    int   w_thr_dest;

    // Main FIFO
    logic [DATA_W-1:0]  w_main_head;
    logic [MAIN_CW-1:0] w_main_count;
    logic               w_main_empty;
    logic               w_main_full;
    logic               w_main_of;
    logic               w_main_uf;
    logic [VC_W-1:0]    w_main_vc;
    logic               w_main_pop;

    // VC FIFOs
    logic [DATA_W-1:0]  w_vc_head  [NUM_VC];
    logic [CNT_W-1:0]   w_vc_count [NUM_VC];
    logic [DST_W-1:0]   w_vc_dst   [NUM_VC];
    logic [NUM_VC-1:0]  w_vc_empty;
    logic [NUM_VC-1:0]  w_vc_full;
    logic [NUM_VC-1:0]  w_vc_of;
    logic [NUM_VC-1:0]  w_vc_uf;
    logic [NUM_VC-1:0]  w_vc_elig;

    // Arbiter
    logic               w_gnt_valid;
    logic [VC_W-1:0]    w_gnt_idx;
    logic [VC_W-1:0]    w_idx;
    logic [DST_W-1:0]   w_gnt_dst;
    logic [DATA_W-1:0]  w_gnt_word;

    // Egress FIFOs
    logic [DATA_W-1:0]          w_d_head  [NUM_DEST];
    logic [DEST_CW-1:0]         w_d_count [NUM_DEST];
    logic [NUM_DEST-1:0]        w_d_empty;
    logic [NUM_DEST-1:0]        w_d_full;
    logic [NUM_DEST-1:0]        w_d_of;
    logic [NUM_DEST-1:0]        w_d_uf;
    logic [NUM_DEST*DATA_W-1:0] w_d_data;

    assign w_live = (r_state != ST_RESET);
    assign w_run  = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);

    // A threshold above a FIFO's depth behaves as the depth itself, so "count < threshold"
    // also guarantees the FIFO is not full.
    always_comb begin
        w_thr_main = (int'(r_thr) > MAIN_DEPTH) ? MAIN_DEPTH : int'(r_thr);
        w_thr_vc   = (int'(r_thr) > VC_DEPTH)   ? VC_DEPTH   : int'(r_thr);
        w_thr_dest = (int'(r_thr) > DEST_DEPTH) ? DEST_DEPTH : int'(r_thr);
    end

    qos_sync_fifo #(.DATA_W(DATA_W), .DEPTH(MAIN_DEPTH)) u_main_fifo (
        .clk      (clk),
        .reset_L  (reset_L),
        .wr       (w_live && bus.Main_wr),
        .rd       (w_main_pop),
        .data_in  (bus.Main_data_in),
        .data_out (w_main_head),
        .count    (w_main_count),
        .empty    (w_main_empty),
        .full     (w_main_full),
        .err_of   (w_main_of),
        .err_uf   (w_main_uf)
    );

    assign w_main_vc  = VC_W'(vc_of(64'(w_main_head), DATA_W, DST_W, VC_W));
    assign w_main_pop = w_run && !w_main_empty && !w_vc_full[w_main_vc]
                        && (int'(w_vc_count[w_main_vc]) < w_thr_vc);

    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
        qos_sync_fifo #(.DATA_W(DATA_W), .DEPTH(VC_DEPTH)) u_vc_fifo (
            .clk      (clk),
            .reset_L  (reset_L),
            .wr       (w_main_pop && (w_main_vc == VC_W'(gi))),
            .rd       (w_gnt_valid && (w_gnt_idx == VC_W'(gi))),
            .data_in  (w_main_head),
            .data_out (w_vc_head[gi]),
            .count    (w_vc_count[gi]),
            .empty    (w_vc_empty[gi]),
            .full     (w_vc_full[gi]),
            .err_of   (w_vc_of[gi]),
            .err_uf   (w_vc_uf[gi])
        );
        assign w_vc_dst[gi]  = DST_W'(dest_of(64'(w_vc_head[gi]), DATA_W, DST_W));
        assign w_vc_elig[gi] = w_run && !w_vc_empty[gi] && !w_d_full[w_vc_dst[gi]]
                               && (int'(w_d_count[w_vc_dst[gi]]) < w_thr_dest);
    end

    // Search order: VC0 upward in strict-priority mode, or starting just after the last
    // granted VC in round-robin mode. Index arithmetic wraps because NUM_VC is a power of 2.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_idx       = '0;
        for (int k = 0; k < NUM_VC; k++) begin
            w_idx = (ARB_MODE == ARB_RR) ? VC_W'(int'(r_rr_last) + 1 + k) : VC_W'(k);
            if (!w_gnt_valid && w_vc_elig[w_idx]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_idx;
            end
        end
    end

    assign w_gnt_dst  = w_vc_dst[w_gnt_idx];
    assign w_gnt_word = w_vc_head[w_gnt_idx];

    for (genvar gj = 0; gj < NUM_DEST; gj++) begin : g_dest
        qos_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEST_DEPTH)) u_dest_fifo (
            .clk      (clk),
            .reset_L  (reset_L),
            .wr       (w_gnt_valid && (w_gnt_dst == DST_W'(gj))),
            .rd       (w_live && bus.D_rd[gj]),
            .data_in  (w_gnt_word),
            .data_out (w_d_head[gj]),
            .count    (w_d_count[gj]),
            .empty    (w_d_empty[gj]),
            .full     (w_d_full[gj]),
            .err_of   (w_d_of[gj]),
            .err_uf   (w_d_uf[gj])
        );
    end

    always_comb begin
        w_d_data = '0;
        for (int j = 0; j < NUM_DEST; j++) begin
            w_d_data[j*DATA_W +: DATA_W] = w_d_head[j];
        end
    end

    assign w_any_data = !w_main_empty || !(&w_vc_empty) || !(&w_d_empty);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RESET:  w_state_nxt = ST_INIT;
            ST_INIT:   if (!init) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (init)                             w_state_nxt = ST_INIT;
                else if (w_any_data || bus.Main_wr)   w_state_nxt = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                             w_state_nxt = ST_INIT;
                else if (!w_any_data && !bus.Main_wr) w_state_nxt = ST_IDLE;
            end
            default:   w_state_nxt = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state   <= ST_RESET;
            r_thr     <= '0;
            r_rr_last <= VC_W'(NUM_VC - 1);
            r_err     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_thr <= umbral_alto;
            end
            if (w_gnt_valid) begin
                r_rr_last <= w_gnt_idx;
            end
            // Errors are wiped on the edge that enters INIT and accumulate otherwise.
            if (r_state != ST_INIT && w_state_nxt == ST_INIT) begin
                r_err <= '0;
            end else begin
                r_err <= r_err | {w_d_of | w_d_uf, w_vc_of | w_vc_uf, w_main_of, w_main_uf};
            end
        end
    end

    assign bus.Main_full  = w_main_full;
    assign bus.Main_pause = w_live && (int'(w_main_count) >= w_thr_main);
    assign bus.D_data_out = w_d_data;
    assign bus.D_empty    = w_d_empty;
    assign VC_empty       = w_vc_empty;
    assign error_out      = r_err;
    assign state          = r_state;
    assign idle_out       = (r_state == ST_IDLE);
endmodule

// File: tb/tb_qos_vc_router.sv
// tb/tb_qos_vc_router.sv - bench for qos_vc_router, strict-priority and round-robin instances
module tb_qos_vc_router;
    localparam int DW = 6, NV = 4, ND = 2, MD = 8, VD = 16, DD = 4, CW = 5, EW = 2 + NV + ND;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           t_rst_n;
    logic           t_init;
    logic [CW-1:0]  t_thr;
    logic           t_wr;
    logic [DW-1:0]  t_data;
    logic [ND-1:0]  t_rd;

    qos_vc_router_if #(.DATA_W(DW), .NUM_DEST(ND)) bus0 ();
    qos_vc_router_if #(.DATA_W(DW), .NUM_DEST(ND)) bus1 ();

    assign bus0.Main_wr = t_wr;  assign bus0.Main_data_in = t_data;  assign bus0.D_rd = t_rd;
    assign bus1.Main_wr = t_wr;  assign bus1.Main_data_in = t_data;  assign bus1.D_rd = t_rd;

    logic [ND-1:0]    o_dempty [2];
    logic [ND*DW-1:0] o_ddata  [2];
    logic             o_mfull  [2];
    logic             o_mpause [2];
    logic [NV-1:0]    o_vce    [2];
    logic [EW-1:0]    o_err    [2];
    logic [1:0]       o_state  [2];
    logic             o_idle   [2];

    assign o_dempty[0] = bus0.D_empty;  assign o_ddata[0] = bus0.D_data_out;
    assign o_mfull[0]  = bus0.Main_full; assign o_mpause[0] = bus0.Main_pause;
    assign o_dempty[1] = bus1.D_empty;  assign o_ddata[1] = bus1.D_data_out;
    assign o_mfull[1]  = bus1.Main_full; assign o_mpause[1] = bus1.Main_pause;

    qos_vc_router #(.DATA_W(DW), .NUM_VC(NV), .NUM_DEST(ND), .MAIN_DEPTH(MD), .VC_DEPTH(VD),
                    .DEST_DEPTH(DD), .ARB_MODE(0)) u_dut_sp (
        .clk(clk), .reset_L(t_rst_n), .init(t_init), .umbral_alto(t_thr), .bus(bus0),
        .VC_empty(o_vce[0]), .error_out(o_err[0]), .state(o_state[0]), .idle_out(o_idle[0]));

    qos_vc_router #(.DATA_W(DW), .NUM_VC(NV), .NUM_DEST(ND), .MAIN_DEPTH(MD), .VC_DEPTH(VD),
                    .DEST_DEPTH(DD), .ARB_MODE(1)) u_dut_rr (
        .clk(clk), .reset_L(t_rst_n), .init(t_init), .umbral_alto(t_thr), .bus(bus1),
        .VC_empty(o_vce[1]), .error_out(o_err[1]), .state(o_state[1]), .idle_out(o_idle[1]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one set of queues per instance (0 = strict priority, 1 = round-robin).
    logic [DW-1:0] mq_main [2][$];
    logic [DW-1:0] mq_vc   [2][NV][$];
    logic [DW-1:0] mq_d    [2][ND][$];
    int            ms_state [2];
    int            ms_thr   [2];
    int            ms_rr    [2];
    logic [EW-1:0] ms_err   [2];

    function automatic int dst_of(logic [DW-1:0] w); return int'(w) / 32;      endfunction
    function automatic int vcx_of(logic [DW-1:0] w); return (int'(w) / 8) % 4; endfunction
    function automatic int sat(int t, int d);        return (t > d) ? d : t;    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq_main[m].delete();
            for (int i = 0; i < NV; i++) mq_vc[m][i].delete();
            for (int j = 0; j < ND; j++) mq_d[m][j].delete();
            ms_state[m] = 0; ms_thr[m] = 0; ms_rr[m] = NV - 1; ms_err[m] = '0;
        end
    endtask

    task automatic model_step(input int m);
        int st, nst, tv, td, g, idx, sz_main;
        bit run, any, main_pop;
        logic [EW-1:0] errnow;
        logic [DW-1:0] w;
        st = ms_state[m];
        run = (st == 2) || (st == 3);
        tv = sat(ms_thr[m], VD);
        td = sat(ms_thr[m], DD);
        sz_main = mq_main[m].size();
        any = (sz_main > 0);
        for (int i = 0; i < NV; i++) if (mq_vc[m][i].size() > 0) any = 1;
        for (int j = 0; j < ND; j++) if (mq_d[m][j].size() > 0) any = 1;
        main_pop = 0;
        if (run && sz_main > 0)
            if (mq_vc[m][vcx_of(mq_main[m][0])].size() < tv) main_pop = 1;
        g = -1;
        if (run) begin
            for (int k = 0; k < NV; k++) begin
                idx = (m == 1) ? (ms_rr[m] + 1 + k) % NV : k;
                if (g < 0 && mq_vc[m][idx].size() > 0) begin
                    w = mq_vc[m][idx][0];
                    if (mq_d[m][dst_of(w)].size() < td) g = idx;
                end
            end
        end
        errnow = '0;
        if (st != 0 && t_wr && sz_main == MD) errnow[1] = 1'b1;
        for (int j = 0; j < ND; j++) begin
            if (st != 0 && t_rd[j]) begin
                if (mq_d[m][j].size() == 0) errnow[2+NV+j] = 1'b1;
                else void'(mq_d[m][j].pop_front());
            end
        end
        if (g >= 0) begin
            w = mq_vc[m][g].pop_front();
            mq_d[m][dst_of(w)].push_back(w);
            ms_rr[m] = g;
        end
        if (main_pop) begin
            w = mq_main[m].pop_front();
            mq_vc[m][vcx_of(w)].push_back(w);
        end
        if (st != 0 && t_wr && sz_main < MD) mq_main[m].push_back(t_data);
        case (st)
            0:       nst = 1;
            1:       nst = t_init ? 1 : 2;
            2:       nst = t_init ? 1 : ((any || t_wr) ? 3 : 2);
            default: nst = t_init ? 1 : ((!any && !t_wr) ? 2 : 3);
        endcase
        if (st == 1) ms_thr[m] = int'(t_thr);
        if (st != 1 && nst == 1) ms_err[m] = '0;
        else                     ms_err[m] = ms_err[m] | errnow;
        ms_state[m] = nst;
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            logic [ND-1:0]    e_dempty;
            logic [ND*DW-1:0] e_ddata;
            logic [NV-1:0]    e_vce;
            e_dempty = '0; e_ddata = '0; e_vce = '0;
            for (int j = 0; j < ND; j++) begin
                e_dempty[j] = (mq_d[m][j].size() == 0);
                if (mq_d[m][j].size() > 0) e_ddata[j*DW +: DW] = mq_d[m][j][0];
            end
            for (int i = 0; i < NV; i++) e_vce[i] = (mq_vc[m][i].size() == 0);
            check($sformatf("m%0d_d_empty", m), o_dempty[m], e_dempty);
            check($sformatf("m%0d_d_data", m), o_ddata[m], e_ddata);
            check($sformatf("m%0d_main_full", m), o_mfull[m], mq_main[m].size() == MD);
            check($sformatf("m%0d_main_pause", m), o_mpause[m],
                  ms_state[m] != 0 && mq_main[m].size() >= sat(ms_thr[m], MD));
            check($sformatf("m%0d_vc_empty", m), o_vce[m], e_vce);
            check($sformatf("m%0d_error", m), o_err[m], ms_err[m]);
            check($sformatf("m%0d_state", m), o_state[m], 64'(ms_state[m]));
            check($sformatf("m%0d_idle", m), o_idle[m], ms_state[m] == 2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (t_rst_n) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_init(input int thr);
        t_thr = CW'(thr);
        t_init = 1'b1;
        tick();
        tick();
        t_init = 1'b0;
        tick();
    endtask

    task automatic push(input logic [DW-1:0] w);
        t_wr = 1'b1;
        t_data = w;
        tick();
        t_wr = 1'b0;
    endtask

    logic [DW-1:0] got [2][$];

    task automatic drain_d0(input int cycles);
        got[0].delete();
        got[1].delete();
        t_rd = 2'b01;
        for (int c = 0; c < cycles; c++) begin
            for (int m = 0; m < 2; m++)
                if (!o_dempty[m][0]) got[m].push_back(o_ddata[m][DW-1:0]);
            tick();
        end
        t_rd = 2'b00;
    endtask

    logic [DW-1:0] pre [10];
    logic [DW-1:0] exp_sp [10];
    logic [DW-1:0] exp_rr [10];
    int init_cnt;

    initial begin
        pre    = '{6'o30, 6'o31, 6'o32, 6'o33, 6'o11, 6'o21, 6'o12, 6'o22, 6'o13, 6'o23};
        exp_sp = '{6'o30, 6'o31, 6'o32, 6'o33, 6'o11, 6'o12, 6'o13, 6'o21, 6'o22, 6'o23};
        exp_rr = '{6'o30, 6'o31, 6'o32, 6'o33, 6'o11, 6'o21, 6'o12, 6'o22, 6'o13, 6'o23};

        t_rst_n = 1'b0; t_init = 1'b1; t_thr = CW'(3); t_wr = 1'b0; t_data = '0; t_rd = '0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("reset_state", o_state[0], 0);
        check("reset_d_empty", o_dempty[0], 2'b11);
        check("reset_pause", o_mpause[0], 0);

        // Reset release, INIT with threshold 3, then IDLE.
        t_rst_n = 1'b1;
        tick();
        check("state_init", o_state[0], 1);
        tick();
        t_init = 1'b0;
        tick();
        check("state_idle", o_state[1], 2);
        check("idle_err", o_err[0], 0);
        check("idle_vc_empty", o_vce[0], 4'hF);

        // Minimum latency: dest 1, VC 0.
        push(6'b100101);
        check("lat_n_d_empty", o_dempty[0][1], 1);
        check("lat_n_state", o_state[0], 3);
        tick();
        check("lat_n1_vc0", o_vce[0][0], 0);
        tick();
        check("lat_n2_d_empty", o_dempty[0][1], 0);
        check("lat_n2_data", o_ddata[0][2*DW-1:DW], 6'b100101);
        t_rd = 2'b10;
        tick();
        t_rd = 2'b00;
        repeat (3) tick();

        // Arbitration: D0 blocked by four VC3 words, VC1/VC2 preloaded behind it.
        do_init(4);
        for (int k = 0; k < 10; k++) push(pre[k]);
        repeat (20) tick();
        check("pre_vc_sp", o_vce[0], 4'b1001);
        check("pre_vc_rr", o_vce[1], 4'b1001);
        drain_d0(30);
        check("arb_cnt_sp", got[0].size(), 10);
        check("arb_cnt_rr", got[1].size(), 10);
        for (int k = 0; k < 10; k++) begin
            if (k < got[0].size()) check($sformatf("arb_sp_%0d", k), got[0][k], exp_sp[k]);
            if (k < got[1].size()) check($sformatf("arb_rr_%0d", k), got[1][k], exp_rr[k]);
        end

        // Threshold 2: six dest-0 words back up D0 -> VC0 -> Main.
        do_init(2);
        for (int k = 1; k <= 6; k++) push(DW'(k));
        repeat (15) tick();
        check("thr_pause", o_mpause[0], 1);
        check("thr_full", o_mfull[0], 0);
        check("thr_vc0", o_vce[0][0], 0);
        drain_d0(30);
        check("thr_cnt", got[0].size(), 6);
        for (int k = 0; k < 6 && k < got[0].size(); k++)
            check($sformatf("thr_order_%0d", k), got[0][k], DW'(k + 1));

        // Underflow error, then INIT clears it while D1 keeps its word.
        push(6'b100111);
        repeat (5) tick();
        t_rd = 2'b01;
        tick();
        t_rd = 2'b00;
        check("uf_err_sp", o_err[0], 8'h40);
        check("uf_err_rr", o_err[1], 8'h40);
        t_init = 1'b1;
        tick();
        check("init_state", o_state[0], 1);
        check("init_err_clr", o_err[0], 0);
        check("init_d1_kept", o_ddata[0][2*DW-1:DW], 6'b100111);
        tick();
        t_init = 1'b0;
        tick();
        check("resume_idle", o_state[0], 2);
        tick();
        check("resume_active", o_state[0], 3);
        t_rd = 2'b10;
        tick();
        t_rd = 2'b00;

        // Randomized traffic with occasional INIT and one asynchronous reset.
        init_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            t_wr   = ($urandom_range(0, 9) < 6);
            t_data = DW'($urandom);
            t_rd   = ND'($urandom);
            if (init_cnt > 0) begin
                init_cnt--;
                t_init = 1'b1;
            end else if ($urandom_range(0, 49) == 0) begin
                init_cnt = $urandom_range(0, 2);
                t_thr = CW'($urandom_range(0, 20));
                t_init = 1'b1;
            end else begin
                t_init = 1'b0;
            end
            if (c == 700) begin
                #2;
                t_rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
                tick();
                t_rst_n = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/qos_vc_router.md
Name: qos_vc_router

Overview:
- Parametrised successor of the two-VC/two-destination interconnect.
- Ingress word enters a Main FIFO, is routed by its class field into one of NUM_VC virtual-channel FIFOs, then arbitrated by its destination field into one of NUM_DEST egress FIFOs.
- Adds a control FSM (RESET/INIT/IDLE/ACTIVE), programmable almost-full thresholds latched in INIT, threshold-based backpressure, and a selectable strict-priority or round-robin VC arbiter.

Parameters:
- DATA_W, 6, word width in bits.
- NUM_VC, 4, number of VC FIFOs. Power of 2, at least 2.
- NUM_DEST, 2, number of egress FIFOs. Power of 2, at least 2.
- MAIN_DEPTH, 8, Main FIFO entries. Power of 2.
- VC_DEPTH, 16, entries per VC FIFO. Power of 2.
- DEST_DEPTH, 4, entries per egress FIFO. Power of 2.
- ARB_MODE, 0, VC arbitration mode: 0 = strict priority (VC0 highest), 1 = round-robin.
- Derived: VC_W = $clog2(NUM_VC), DST_W = $clog2(NUM_DEST), CNT_W = $clog2(VC_DEPTH)+1.

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous active-low reset.
- init  in  1  enters or holds INIT; thresholds are sampled while it is high.
- umbral_alto  in  CNT_W  almost-full threshold. Applies to every FIFO, saturated to each FIFO's depth.
- Main_wr  in  1  push request into the Main FIFO.
- Main_data_in  in  DATA_W  ingress word.
- D_rd  in  NUM_DEST  per-destination pop. Bit i pops egress FIFO i.
- D_data_out  out  NUM_DEST*DATA_W  egress head words, show-ahead. Slice i belongs to FIFO i.
- D_empty  out  NUM_DEST  per-egress empty.
- Main_full  out  1  Main FIFO full.
- Main_pause  out  1  Main FIFO count >= latched threshold.
- VC_empty  out  NUM_VC  per-VC empty.
- error_out  out  2+NUM_VC+NUM_DEST  sticky error flags. Order: {D errors, VC errors, Main overflow, Main underflow}.
- state  out  2  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- idle_out  out  1  high when state is IDLE.

Behaviour:
- Reset (reset_L low, asynchronous):
  - All FIFOs are emptied and their pointers cleared.
  - state=RESET, latched threshold = 0, error_out = 0.
  - All empty outputs = 1; Main_full=0, Main_pause=0, idle_out=0.
  - D_data_out = 0.
- Word fields:
  - Destination = Main_data_in[DATA_W-1 -: DST_W].
  - VC = the next VC_W bits below the destination field.
  - Words are forwarded unmodified.
- FSM transitions:
  - RESET -> INIT on the first clock after reset_L rises.
  - INIT: latch umbral_alto every cycle. Go to IDLE when init=0.
  - IDLE: go to ACTIVE if any FIFO is non-empty or Main_wr=1.
  - ACTIVE: go to IDLE when all FIFOs are empty and Main_wr=0.
  - IDLE or ACTIVE -> INIT when init=1. Entering INIT clears error_out.
  - FIFO contents survive INIT; no traffic moves while in INIT.
- FIFOs (all instances):
  - Synchronous, with registered count.
  - Data out is the combinational head (show-ahead).
  - A write makes empty deassert on the next cycle.
  - Simultaneous read and write while non-empty and non-full: count is unchanged.
- Main -> VC stage, in IDLE/ACTIVE:
  - Pop the Main head when Main is non-empty and the target VC count < threshold (not almost-full).
  - The popped word is written into that VC in the same edge.
- VC -> Dest stage, in IDLE/ACTIVE:
  - Eligible VC: non-empty, and its head's destination FIFO count < threshold.
  - At most one VC pops per cycle and writes its target egress FIFO in the same edge.
  - ARB_MODE=0: grant the lowest-index eligible VC.
  - ARB_MODE=1: grant the first eligible VC after the last granted one. The pointer advances only on a grant and wraps at NUM_VC-1 -> 0.
- Minimum latency: Main_wr at edge N -> VC non-empty after N+1 -> D_empty low after edge N+2 (3 cycles).
- Overflow and underflow:
  - Main_wr while full: word is dropped, Main overflow flag set.
  - Any D_rd bit asserted while that FIFO is empty: its flag is set, pointers unchanged.
  - Internal stages never over- or underflow, so VC error bits remain 0.
  - All flags are sticky until reset or INIT.
- Threshold 0 blocks the corresponding stage entirely; this is legal and requires no special casing.
- Main_wr and D_rd are honoured in every state except RESET. Traffic stalls in INIT only in the internal stages.

Decomposition:
- Package qos_pkg holds:
  - the state encodings;
  - ARB_SP and ARB_RR constants;
  - field-extract functions dest_of() and vc_of(), parameterised by widths.
- One sub-module, qos_sync_fifo (DATA_W, DEPTH). Ports: wr, rd, data_in, data_out, count, empty, full, err_of, err_uf.
- Instantiated 1 + NUM_VC + NUM_DEST times via generate loops.
- Arbiter and FSM are inline in qos_vc_router.

Test Plan:
- Reset then init=1 with umbral_alto=3, then init=0.
  - Required: state goes 0->1->2; all *_empty=1; error_out=0.
- Push 0b10_0101 (dest 1, VC 0) at edge N, D_rd=0.
  - Required: D_empty[1]=0 after edge N+2; D_data_out slice 1 = 0b100101; state ACTIVE.
- ARB_MODE=0, VC1 and VC2 both preloaded with dest-0 words.
  - Required: all VC1 words egress before any VC2 word.
- ARB_MODE=1, same preload.
  - Required: egress alternates VC1, VC2, VC1, ...
- Threshold 2, D_rd=0, 6 words pushed to dest 0.
  - Required: D0 holds exactly 2 words; the remaining words back up through VC to Main; Main_pause=1 once Main count reaches 2.
- Pop an empty D0, then assert init=1.
  - Required: error_out D0 bit=1 after the pop; cleared on INIT entry; FIFO contents preserved; IDLE or ACTIVE resumes after init=0.
